// File: rtl/tick_period_meter.sv
// Measures the gap between one-cycle ticks and reports the period d of a divider
// that pulses every d+1 clocks. Locks after LOCK_COUNT consecutive matches with expected.
module tick_period_meter #(
   parameter int WIDTH      = 28,
   parameter int LOCK_COUNT = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             tick_in,
   input  logic [WIDTH-1:0] expected,
   output logic [WIDTH-1:0] period_q,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout,
   output logic [3:0]       tick_count
);

   typedef enum logic {IDLE, MEASURE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] gap, gap_nx;
   logic [WIDTH-1:0] period_nx;
   logic             valid_nx, locked_nx, timeout_nx;
   logic [3:0]       count_nx;
   logic [3:0]       match, match_nx;

   function automatic logic lock_reached(input logic [3:0] m);
      return ({1'b0, m} + 5'd1) >= 5'(LOCK_COUNT);
   endfunction

   function automatic logic [3:0] match_sat_inc(input logic [3:0] m);
      if (lock_reached(m))
         return 4'(LOCK_COUNT);
      return m + 4'd1;
   endfunction

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state        <= IDLE;
         gap          <= '0;
         period_q     <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         tick_count   <= 4'd0;
         match        <= 4'd0;
      end else begin
         state        <= state_nx;
         gap          <= gap_nx;
         period_q     <= period_nx;
         period_valid <= valid_nx;
         locked       <= locked_nx;
         timeout      <= timeout_nx;
         tick_count   <= count_nx;
         match        <= match_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      gap_nx     = gap;
      period_nx  = period_q;
      valid_nx   = 1'b0;
      timeout_nx = 1'b0;
      locked_nx  = locked;
      count_nx   = tick_count;
      match_nx   = match;
      unique case (state)
         IDLE: begin
            gap_nx = '0;
            if (tick_in) begin
               state_nx = MEASURE;
               count_nx = tick_count + 4'd1;
            end
         end
         MEASURE: begin
            // A tick coinciding with saturation is still a valid measurement.
            if (tick_in) begin
               period_nx = gap;
               valid_nx  = 1'b1;
               gap_nx    = '0;
               count_nx  = tick_count + 4'd1;
               if (gap == expected) begin
                  match_nx  = match_sat_inc(match);
                  locked_nx = locked | lock_reached(match);
               end else begin
                  match_nx  = 4'd0;
                  locked_nx = 1'b0;
               end
            end else if (&gap) begin
               state_nx   = IDLE;
               gap_nx     = '0;
               timeout_nx = 1'b1;
               locked_nx  = 1'b0;
               match_nx   = 4'd0;
            end else begin
               gap_nx = gap + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: a full-width instance and a WIDTH=4
// instance exercising timeout and saturation boundaries.
module tb_tick_period_meter;

   logic        clock;
   logic        reset_n, tick_in;
   logic [27:0] expected;
   logic [27:0] period_q;
   logic        period_valid, locked, timeout;
   logic [3:0]  tick_count;

   logic        reset_n4, tick4;
   logic [3:0]  expected4;
   logic [3:0]  period_q4;
   logic        period_valid4, locked4, timeout4;
   logic [3:0]  tick_count4;

   int vectors     = 0;
   int miscompares = 0;

   tick_period_meter #(.WIDTH(28), .LOCK_COUNT(4)) u_dut (
      .clock(clock), .reset_n(reset_n), .tick_in(tick_in), .expected(expected),
      .period_q(period_q), .period_valid(period_valid), .locked(locked),
      .timeout(timeout), .tick_count(tick_count)
   );

   tick_period_meter #(.WIDTH(4), .LOCK_COUNT(4)) u_dut4 (
      .clock(clock), .reset_n(reset_n4), .tick_in(tick4), .expected(expected4),
      .period_q(period_q4), .period_valid(period_valid4), .locked(locked4),
      .timeout(timeout4), .tick_count(tick_count4)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic t);
      tick_in = t;
      @(posedge clock);
      #1;
   endtask

   task automatic drive4(input logic t);
      tick4 = t;
      @(posedge clock);
      #1;
   endtask

   task automatic period_run(input int d);
      for (int i = 0; i < d; i++) drive(1'b0);
      drive(1'b1);
   endtask

   task automatic period_run4(input int d);
      for (int i = 0; i < d; i++) drive4(1'b0);
      drive4(1'b1);
   endtask

   initial begin
      reset_n = 1'b0; tick_in = 1'b0; expected = 28'd2;
      reset_n4 = 1'b0; tick4 = 1'b0; expected4 = 4'd2;

      // Reset state, then ticks every 3 cycles against expected=2
      drive(1'b0);
      drive(1'b0);
      check("rst_period", 32'(period_q), 32'd0);
      check("rst_valid", 32'(period_valid), 32'd0);
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_count", 32'(tick_count), 32'd0);
      reset_n = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         drive(1'b1);
         check("t1_valid", 32'(period_valid), 32'(k > 1));
         if (k > 1) check("t1_period", 32'(period_q), 32'd2);
         check("t1_locked", 32'(locked), 32'(k == 5));
         check("t1_count", 32'(tick_count), 32'(k));
         drive(1'b0);
         check("t1_valid_gap", 32'(period_valid), 32'd0);
         drive(1'b0);
      end

      // Back-to-back ticks, expected=0
      reset_n = 1'b0; expected = 28'd0;
      drive(1'b0);
      reset_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b1);
         check("t2_valid", 32'(period_valid), 32'(k > 1));
         if (k > 1) check("t2_period", 32'(period_q), 32'd0);
         check("t2_locked", 32'(locked), 32'(k >= 5));
         check("t2_count", 32'(tick_count), 32'(k % 16));
      end
      drive(1'b0);

      // Lock at d=4, break with one period of 6, relock
      reset_n = 1'b0; expected = 28'd4;
      drive(1'b0);
      reset_n = 1'b1;
      drive(1'b1);
      for (int j = 1; j <= 4; j++) begin
         period_run(4);
         check("t3_period", 32'(period_q), 32'd4);
         check("t3_locked", 32'(locked), 32'(j == 4));
      end
      period_run(6);
      check("t3_bad_period", 32'(period_q), 32'd6);
      check("t3_bad_valid", 32'(period_valid), 32'd1);
      check("t3_unlocked", 32'(locked), 32'd0);
      for (int j = 1; j <= 4; j++) begin
         period_run(4);
         check("t3_relock", 32'(locked), 32'(j == 4));
      end

      // WIDTH=4: lock, then starve the tick stream until timeout
      drive4(1'b0);
      reset_n4 = 1'b1;
      drive4(1'b1);
      for (int j = 0; j < 4; j++) period_run4(2);
      check("t4_locked", 32'(locked4), 32'd1);
      check("t4_count", 32'(tick_count4), 32'd5);
      for (int i = 1; i <= 16; i++) begin
         drive4(1'b0);
         if (i == 15) check("t4_no_timeout", 32'(timeout4), 32'd0);
         if (i == 16) begin
            check("t4_timeout", 32'(timeout4), 32'd1);
            check("t4_locked_clr", 32'(locked4), 32'd0);
            check("t4_valid_clr", 32'(period_valid4), 32'd0);
         end
      end
      drive4(1'b0);
      check("t4_timeout_pulse", 32'(timeout4), 32'd0);
      drive4(1'b1);
      check("t4_rearm_valid", 32'(period_valid4), 32'd0);
      check("t4_rearm_count", 32'(tick_count4), 32'd6);
      check("t4_rearm_locked", 32'(locked4), 32'd0);
      period_run4(3);
      check("t4_meas_valid", 32'(period_valid4), 32'd1);
      check("t4_meas_period", 32'(period_q4), 32'd3);
      check("t4_meas_count", 32'(tick_count4), 32'd7);

      // WIDTH=4: tick exactly at gap=15
      period_run4(15);
      check("t5_period", 32'(period_q4), 32'd15);
      check("t5_valid", 32'(period_valid4), 32'd1);
      check("t5_timeout", 32'(timeout4), 32'd0);
      drive4(1'b0);
      check("t5_timeout_after", 32'(timeout4), 32'd0);

      // Reset mid-measurement while locked, with a concurrent tick
      reset_n = 1'b0; expected = 28'd2;
      drive(1'b0);
      reset_n = 1'b1;
      drive(1'b1);
      for (int j = 0; j < 4; j++) period_run(2);
      check("t6_locked", 32'(locked), 32'd1);
      drive(1'b0);
      reset_n = 1'b0;
      drive(1'b1);
      check("t6_period", 32'(period_q), 32'd0);
      check("t6_valid", 32'(period_valid), 32'd0);
      check("t6_locked_clr", 32'(locked), 32'd0);
      check("t6_timeout", 32'(timeout), 32'd0);
      check("t6_count", 32'(tick_count), 32'd0);
      reset_n = 1'b1;
      drive(1'b1);
      check("t6_rearm_valid", 32'(period_valid), 32'd0);
      check("t6_rearm_count", 32'(tick_count), 32'd1);
      period_run(2);
      check("t6_meas_valid", 32'(period_valid), 32'd1);
      check("t6_meas_period", 32'(period_q), 32'd2);
      check("t6_meas_count", 32'(tick_count), 32'd2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tick_period_meter.md
# tick_period_meter

Measures the spacing of a one-cycle tick stream and recovers the period value that produced it. It is the receive-side counterpart of the rate-divider enable generator: a divider loaded with period d pulses every d+1 clocks, and this block reports d. It also flags lock once the measured period matches an expected value several times in a row. It sits downstream of any tick source, such as a game-timer tick or a toggle enable, and feeds LEDs, the hex display path, and timeout logic.

## Interface
- WIDTH, 28, width of the period counter and of the period values
- LOCK_COUNT, 4, number of consecutive matching periods required to assert locked (1..15)
- clock  input  1  rising-edge clock
- reset_n  input  1  synchronous, active-low reset
- tick_in  input  1  tick stream; each cycle it is sampled high counts as one tick
- expected  input  WIDTH  period value d to lock against; sampled at each measurement
- period_q  output  WIDTH  last measured period (gap cycles between ticks)
- period_valid  output  1  one-cycle pulse when period_q updates
- locked  output  1  high after LOCK_COUNT consecutive matches with expected
- timeout  output  1  one-cycle pulse when the gap counter saturates
- tick_count  output  4  accepted ticks modulo 16

## Operation
- State machine with two states, IDLE and MEASURE. The state is not exported.
- IDLE: gap counter is held at 0.
  - tick_in=1 → go to MEASURE, gap<=0, tick_count+1.
  - No period is reported for this first tick.
- MEASURE, tick_in=0: gap<=gap+1.
- MEASURE, tick_in=0 and gap == all-ones (2^WIDTH−1):
  - Go to IDLE and pulse timeout.
  - Clear locked and the match counter.
  - period_q is unchanged.
- MEASURE, tick_in=1:
  - period_q<=gap, period_valid<=1, gap<=0, stay in MEASURE, tick_count+1.
- Match counter (4-bit) is evaluated on every measurement:
  - gap == expected → match<=min(match+1, LOCK_COUNT), and locked<=1 when match+1 ≥ LOCK_COUNT.
  - gap != expected → match<=0, locked<=0.
- Back-to-back ticks (every cycle) measure as period 0. Ticks every d+1 cycles measure as d.
- tick_count wraps from 15 to 0. It counts every accepted tick, including the first one from IDLE.
- A change on expected takes effect at the next measurement only. Lock history is not re-evaluated retroactively.

## Timing
- All outputs are registered.
- A tick sampled at edge N is reflected in period_q, period_valid, locked and tick_count after edge N. Latency is 1 cycle from tick_in to outputs.
- period_valid and timeout are exactly one cycle wide and never assert in the same cycle.
- Reset values: period_q=0, period_valid=0, locked=0, timeout=0, tick_count=0, gap=0, match=0, state=IDLE.
- reset_n=0 overrides all other inputs, including a concurrent tick. Reset mid-measurement discards the partial gap.
- Tick in the same cycle as saturation: the tick wins. A measurement of 2^WIDTH−1 is reported and no timeout occurs.
- First tick after a timeout re-arms only: no period is reported and locked stays 0.
- locked can assert no earlier than the LOCK_COUNT-th measurement, which is the (LOCK_COUNT+1)-th tick after reset or timeout.

## Test plan
- **Reset, then ticks every 3 cycles, expected=2:** measurements 2,2,2,2.
  - period_valid pulses every 3 cycles.
  - locked rises one cycle after the 5th tick.
  - tick_count=5.
- **Back-to-back ticks for 20 cycles, expected=0:**
  - period_q=0 and period_valid high every cycle from the 2nd tick onward.
  - locked after the 5th tick.
  - tick_count wraps to 4.
- **Locked at d=4, then one gap of 6 cycles (measures 6):**
  - locked drops one cycle after that tick.
  - The match counter restarts, and locked re-asserts after 4 further correct periods.
- **WIDTH=4, one tick, then tick_in held low:**
  - timeout pulses once 16 cycles after the tick.
  - locked=0 and the state returns to IDLE.
  - The next tick gives no period_valid; the following tick reports its gap.
- **WIDTH=4, tick exactly when gap=15:** period_q=15, period_valid=1, no timeout.
- **Mid-measurement reset:**
  - Assert reset_n=0 for 1 cycle together with tick_in=1 while locked.
  - All outputs are 0 next cycle and tick_count stays 0.
  - Measuring restarts from IDLE.
